// File: rtl/tick_generator_pkg.sv
// Shared constants and types for the multi-channel tick generator.
// Divisor values assume the 50 MHz system clock; a divisor D yields a
// tick every D+1 cycles.
package tick_pkg;

  localparam int unsigned CLK_HZ    = 50_000_000;
  localparam int unsigned CNT_W_DEF = 28;
  localparam int unsigned MAX_CH    = 16;

  // Common rates: tick period is (div + 1) clock cycles.
  localparam int unsigned DIV_1HZ  = 49_999_999;
  localparam int unsigned DIV_2HZ  = 24_999_999;
  localparam int unsigned DIV_60HZ = 833_332;

  // Reset divisor: 2 Hz tick, which makes a 1 Hz square.
  localparam int unsigned DEFAULT_DIV = DIV_2HZ;

  // Wide enough to index any legal channel count (up to MAX_CH).
  typedef logic [3:0] ch_idx_t;

  // Divisor producing a tick rate of hz at CLK_HZ.
  function automatic int unsigned div_for_hz(input int unsigned hz);
    return (CLK_HZ / hz) - 32'd1;
  endfunction

  // Width of the write-channel index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch > 32'd1) ? $clog2(num_ch) : 32'd1;
  endfunction

endpackage

// File: rtl/tick_generator_channel.sv
// One tick channel: divisor, counter, tick strobe and square enable.
// Priority per edge: clear > write > pause > terminal count > count.
module tick_channel
  import tick_pkg::*;
#(
  parameter int unsigned      CNT_W       = tick_pkg::CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(tick_pkg::DEFAULT_DIV)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             square_o
);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;
  logic             term_s;

  // Equality-only terminal compare: cnt is reset to zero whenever div
  // changes, so it can never run past div.
  always_comb begin
    term_s = (cnt_q == div_q);
  end

  // Next-state selection following the per-channel priority order.
  always_comb begin
    div_d    = div_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    square_d = square_q;
    if (clear_i) begin
      // Clear wins over a same-cycle write; the divisor is retained.
      cnt_d    = {CNT_W{1'b0}};
      square_d = 1'b0;
    end else if (wr_i) begin
      // New period begins counting from zero on the following edge.
      div_d    = wr_div_i;
      cnt_d    = {CNT_W{1'b0}};
      square_d = 1'b0;
    end else if (!en_i) begin
      // Paused: hold phase, including a pending terminal count.
      cnt_d    = cnt_q;
      square_d = square_q;
    end else if (term_s) begin
      cnt_d    = {CNT_W{1'b0}};
      tick_d   = 1'b1;
      square_d = ~square_q;
    end else begin
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset restores the default rate and discards phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= DEFAULT_DIV;
      cnt_q    <= {CNT_W{1'b0}};
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick_o   = tick_q;
  assign square_o = square_q;

endmodule

// File: rtl/tick_generator.sv
// Multi-channel programmable tick generator. Each channel emits a
// one-cycle tick strobe and a 50%-duty square enable for use as clock
// enables by game logic. Divisors are writable at run time.
module tick_generator #(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      CNT_W       = tick_pkg::CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(tick_pkg::DEFAULT_DIV)
) (
  input  logic                                           Clk,
  input  logic                                           Reset_n,
  input  logic                                           clear,
  input  logic [NUM_CH-1:0]                              ch_en,
  input  logic                                           wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [CNT_W-1:0]                               wr_div,
  output logic [NUM_CH-1:0]                              tick,
  output logic [NUM_CH-1:0]                              square
);

  import tick_pkg::*;

  localparam int unsigned IDX_W = idx_width(NUM_CH);

  ch_idx_t           wr_idx_s;
  logic              wr_in_range_s;
  logic [NUM_CH-1:0] wr_hit_s;

  // Range check: an index past the last channel is dropped entirely.
  always_comb begin
    wr_idx_s      = ch_idx_t'(wr_ch);
    wr_in_range_s = ({1'b0, wr_idx_s} < 5'(NUM_CH));
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      // One-hot write decode for this channel.
      always_comb begin
        wr_hit_s[g] = wr_en && wr_in_range_s && (wr_idx_s == ch_idx_t'(g));
      end

      tick_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .clear_i  (clear),
        .en_i     (ch_en[g]),
        .wr_i     (wr_hit_s[g]),
        .wr_div_i (wr_div),
        .tick_o   (tick[g]),
        .square_o (square[g])
      );
    end
  endgenerate

  // IDX_W documents the decode width; tie it to the port so a mismatch
  // between the two expressions shows up as a width error.
  logic [IDX_W-1:0] wr_ch_chk_s;
  always_comb begin
    wr_ch_chk_s = wr_ch;
  end

endmodule
